// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the hazard controller.
//   - REG_ADDR_W      register address width (from defines.v)
//   - S_*             state encodings (from defines.v)
//   - hz_ctl_t        bundle of stall / bubble / flush controls
//   - ctl_* helpers   canned control bundles used by the state machine
`include "defines.v"

package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = `REG_ADDR_WIDTH;

  localparam logic [1:0] S_RUN      = `HZ_ST_RUN;
  localparam logic [1:0] S_MEM_WAIT = `HZ_ST_MEM_WAIT;
  localparam logic [1:0] S_REDIRECT = `HZ_ST_REDIRECT;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic bubble_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
  } hz_ctl_t;

  // Whole pipeline frozen behind an outstanding data access.
  function automatic hz_ctl_t ctl_freeze();
    hz_ctl_t c;
    c = '0;
    c.stall_pc     = 1'b1;
    c.stall_if_id  = 1'b1;
    c.stall_id_ex  = 1'b1;
    c.stall_ex_mem = 1'b1;
    return c;
  endfunction

  // Taken branch: squash the two younger instructions.
  function automatic hz_ctl_t ctl_branch();
    hz_ctl_t c;
    c = '0;
    c.flush_if_id = 1'b1;
    c.flush_id_ex = 1'b1;
    return c;
  endfunction

  // Load-use: hold fetch/decode, insert one bubble behind the load.
  function automatic hz_ctl_t ctl_load_use();
    hz_ctl_t c;
    c = '0;
    c.stall_pc     = 1'b1;
    c.stall_if_id  = 1'b1;
    c.bubble_id_ex = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/defines.v
// Shared defines for the hazard controller.
// Register-file address/data widths and the controller state encodings.
// Guarded so it can be included from every file in the slice.
`ifndef HAZARD_DEFINES_V
`define HAZARD_DEFINES_V

`define REG_ADDR_WIDTH 5
`define REG_WIDTH      32

`define HZ_ST_RUN      2'd0
`define HZ_ST_MEM_WAIT 2'd1
`define HZ_ST_REDIRECT 2'd2

`endif

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use detector.
// Ports:
//   rs1_addr, rs2_addr  decode-stage source registers
//   rs1_used, rs2_used  decode instruction actually reads rs1 / rs2
//   rd_addr             execute-stage destination register
//   load                execute instruction is a load
//   load_use            decode needs the load result next cycle
`include "defines.v"

module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  load,
  output logic                  load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = rs1_used & (rs1_addr == rd_addr);
  assign rs2_hit  = rs2_used & (rs2_addr == rd_addr);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = load & (rd_addr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (stalls, bubbles, flushes).
// Optional feature macro: HAZARD_CTRL_PERF_EN enables the two performance
// counters; without it the counter ports are constant zero.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   rs1/rs2_addr_id, rs1/rs2_used_id decode source registers and use flags
//   rd_addr_ex, load_ex              execute destination / load flag
//   branch_taken_ex                  execute redirects the PC
//   dmem_req_mem, dmem_ready         data access issue pulse / completion
//   imem_ready                       fetched instruction valid
//   stall_*, bubble_id_ex, flush_*   pipeline controls (combinational)
//   state_o                          RUN=0, MEM_WAIT=1, REDIRECT=2
//   stall_cycles, flush_events       performance counters
`include "defines.v"

module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [`REG_ADDR_WIDTH-1:0] rs1_addr_id,
  input  logic [`REG_ADDR_WIDTH-1:0] rs2_addr_id,
  input  logic                       rs1_used_id,
  input  logic                       rs2_used_id,
  input  logic [`REG_ADDR_WIDTH-1:0] rd_addr_ex,
  input  logic                       load_ex,
  input  logic                       branch_taken_ex,
  input  logic                       dmem_req_mem,
  input  logic                       dmem_ready,
  input  logic                       imem_ready,
  output logic                       stall_pc,
  output logic                       stall_if_id,
  output logic                       stall_id_ex,
  output logic                       stall_ex_mem,
  output logic                       bubble_id_ex,
  output logic                       flush_if_id,
  output logic                       flush_id_ex,
  output logic [1:0]                 state_o,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flush_events
);

  logic [1:0] state, state_nxt;
  logic       redirect_pend, pend_nxt;
  logic       load_use, mem_miss;
  hz_ctl_t    ctl, ctl_out;

  hazard_cmp u_cmp (
    .rs1_addr (rs1_addr_id),
    .rs2_addr (rs2_addr_id),
    .rs1_used (rs1_used_id),
    .rs2_used (rs2_used_id),
    .rd_addr  (rd_addr_ex),
    .load     (load_ex),
    .load_use (load_use)
  );

  assign mem_miss = dmem_req_mem & ~dmem_ready;

  // Branches are only acted on in cycles where execute is not frozen; every
  // path that freezes execute below takes priority over the branch arm, so a
  // branch held during a freeze is simply seen again on release.
  always_comb begin
    ctl       = '0;
    state_nxt = S_RUN;
    // An arriving fetch always retires a pending redirect; a new branch in
    // the same cycle re-arms it (the fetch belonged to the wrong path).
    pend_nxt  = redirect_pend & ~imem_ready;
    case (state)
      S_RUN: begin
        if (mem_miss) begin
          ctl       = ctl_freeze();
          state_nxt = S_MEM_WAIT;
        end else if (branch_taken_ex) begin
          ctl       = ctl_branch();
          pend_nxt  = 1'b1;
          state_nxt = S_REDIRECT;
        end else if (load_use) begin
          ctl       = ctl_load_use();
        end
      end
      S_MEM_WAIT: begin
        // A new dmem_req_mem pulse cannot belong to a frozen stage; ignore it.
        if (!dmem_ready) begin
          ctl       = ctl_freeze();
          state_nxt = S_MEM_WAIT;
        end else if (branch_taken_ex) begin
          ctl       = ctl_branch();
          pend_nxt  = 1'b1;
          state_nxt = S_REDIRECT;
        end else begin
          if (load_use) ctl = ctl_load_use();
          state_nxt = (redirect_pend & ~imem_ready) ? S_REDIRECT : S_RUN;
        end
      end
      S_REDIRECT: begin
        if (mem_miss) begin
          // Redirect stays pending across the data wait.
          ctl       = ctl_freeze();
          state_nxt = S_MEM_WAIT;
        end else if (!imem_ready) begin
          ctl.stall_pc    = 1'b1;
          ctl.flush_if_id = 1'b1;
          state_nxt       = S_REDIRECT;
        end
      end
      default: begin
        ctl       = '0;
        state_nxt = S_RUN;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RUN;
      redirect_pend <= 1'b0;
    end else begin
      state         <= state_nxt;
      redirect_pend <= pend_nxt;
    end
  end

  // Controls are forced quiet during reset regardless of input activity.
  assign ctl_out      = rst_n ? ctl : '0;
  assign stall_pc     = ctl_out.stall_pc;
  assign stall_if_id  = ctl_out.stall_if_id;
  assign stall_id_ex  = ctl_out.stall_id_ex;
  assign stall_ex_mem = ctl_out.stall_ex_mem;
  assign bubble_id_ex = ctl_out.bubble_id_ex;
  assign flush_if_id  = ctl_out.flush_if_id;
  assign flush_id_ex  = ctl_out.flush_id_ex;
  assign state_o      = state;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic        run_to_redirect;

  assign run_to_redirect = (state == S_RUN) & (state_nxt == S_REDIRECT);

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc)        stall_cnt <= stall_cnt + 32'd1;
      if (run_to_redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vectors with hand-computed expected
// controls pushed to a scoreboard queue; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr_id, rs2_addr_id, rd_addr_ex;
  logic        rs1_used_id, rs2_used_id, load_ex, branch_taken_ex;
  logic        dmem_req_mem, dmem_ready, imem_ready;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        bubble_id_ex, flush_if_id, flush_id_ex;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_addr_ex(rd_addr_ex), .load_ex(load_ex),
    .branch_taken_ex(branch_taken_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .imem_ready(imem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .state_o(state_o),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // ctl order: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble, flush_if_id, flush_id_ex}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] LU = 7'b1100100;
  localparam logic [6:0] MS = 7'b1111000;
  localparam logic [6:0] BR = 7'b0000011;
  localparam logic [6:0] RD = 7'b1000010;

  typedef struct {
    string       nm;
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_sc = 0, exp_fe = 0;

  // One vector per cycle, driven #1 after the rising edge.
  task automatic step(input string nm, input logic rn,
                      input logic ld, input logic [4:0] rd,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic br, input logic dq, input logic dr,
                      input logic ir,
                      input logic [6:0] ex, input logic [1:0] es,
                      input logic rr);
    exp_t e;
    @(posedge clk); #1;
    rst_n = rn; load_ex = ld; rd_addr_ex = rd;
    rs1_addr_id = r1; rs1_used_id = u1; rs2_addr_id = r2; rs2_used_id = u2;
    branch_taken_ex = br; dmem_req_mem = dq; dmem_ready = dr; imem_ready = ir;
    if (!rn) begin exp_sc = 0; exp_fe = 0; end
    e.nm = nm; e.ctl = ex; e.st = es;
`ifdef HAZARD_CTRL_PERF_EN
    e.sc = exp_sc; e.fe = exp_fe;
`else
    e.sc = 0; e.fe = 0;
`endif
    sb.push_back(e);
    if (rn) begin
      exp_sc = exp_sc + {31'd0, ex[6]};
      exp_fe = exp_fe + {31'd0, rr};
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = sb.pop_front();
      act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             bubble_id_ex, flush_if_id, flush_id_ex};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b exp=%b", e.nm, act, e.ctl);
      end
      checks++;
      if (state_o !== e.st) begin
        errors++;
        $display("FAIL %s state got=%0d exp=%0d", e.nm, state_o, e.st);
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s stall_cycles got=%0d exp=%0d", e.nm, stall_cycles, e.sc);
      end
      checks++;
      if (flush_events !== e.fe) begin
        errors++;
        $display("FAIL %s flush_events got=%0d exp=%0d", e.nm, flush_events, e.fe);
      end
    end
  end

  initial begin
    rst_n = 1'b0; load_ex = 0; rd_addr_ex = 0; rs1_addr_id = 0; rs2_addr_id = 0;
    rs1_used_id = 0; rs2_used_id = 0; branch_taken_ex = 0;
    dmem_req_mem = 0; dmem_ready = 1; imem_ready = 1;

    //    name          rn ld rd  r1 u1 r2 u2 br dq dr ir  exp st rr
    step("reset",       0, 1, 5,  0, 0, 5, 1, 1, 1, 0, 1, Z,  0, 0);
    // load-use and its exceptions
    step("lu_rs2",      1, 1, 5,  3, 1, 5, 1, 0, 0, 1, 1, LU, 0, 0);
    step("lu_advanced", 1, 0, 7,  3, 1, 5, 1, 0, 0, 1, 1, Z,  0, 0);
    step("x0_dest",     1, 1, 0,  0, 1, 0, 1, 0, 0, 1, 1, Z,  0, 0);
    step("rs1_unused",  1, 1, 9,  9, 0, 2, 1, 0, 0, 1, 1, Z,  0, 0);
    step("lu_rs1",      1, 1, 9,  9, 1, 2, 1, 0, 0, 1, 1, LU, 0, 0);
    // data miss, ready low 3 cycles; extra request pulse ignored in MEM_WAIT
    step("miss_c0",     1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1, MS, 0, 0);
    step("miss_c1",     1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, MS, 1, 0);
    step("miss_c2",     1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1, MS, 1, 0);
    step("miss_rel",    1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  1, 0);
    step("miss_run",    1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  0, 0);
    // branch beats load-use, slow fetch
    step("br_lu",       1, 1, 5,  0, 0, 5, 1, 1, 0, 1, 0, BR, 0, 1);
    step("redir_1",     1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, RD, 2, 0);
    step("redir_2",     1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, RD, 2, 0);
    step("redir_exit",  1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  2, 0);
    step("redir_run",   1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  0, 0);
    // miss during redirect, fetch not seen -> back to REDIRECT
    step("br_b",        1, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, BR, 0, 1);
    step("rd_miss",     1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, MS, 2, 0);
    step("mw_a",        1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, MS, 1, 0);
    step("mw_exit_a",   1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, Z,  1, 0);
    step("rd_again",    1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, RD, 2, 0);
    step("rd_exit_b",   1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  2, 0);
    step("run_b",       1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  0, 0);
    // miss during redirect, fetch seen while waiting -> RUN
    step("br_c",        1, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, BR, 0, 1);
    step("rd_miss_c",   1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, MS, 2, 0);
    step("mw_seen",     1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, MS, 1, 0);
    step("mw_exit_c",   1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, Z,  1, 0);
    step("run_c",       1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, Z,  0, 0);
    // branch held during a freeze is acted on at release
    step("br_frozen0",  1, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1, MS, 0, 0);
    step("br_frozen1",  1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, MS, 1, 0);
    step("br_release",  1, 0, 0,  0, 0, 0, 0, 1, 0, 1, 1, BR, 1, 0);
    step("br_rel_redir",1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  2, 0);
    step("br_rel_run",  1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, Z,  0, 0);
    // reset in the middle of a data wait
    step("pre_rst_0",   1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1, MS, 0, 0);
    step("pre_rst_1",   1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, MS, 1, 0);
    step("rst_mid_mw",  0, 1, 5,  5, 1, 0, 0, 1, 1, 0, 0, Z,  0, 0);
    step("post_rst",    1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, Z,  0, 0);
    step("post_rst_lu", 1, 1, 4,  4, 1, 0, 0, 0, 0, 0, 1, LU, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
